// File: rtl/ag_tcu_int_pkg.sv
// rtl/ag_tcu_int_pkg.sv - shared constants and helpers for the integer FEDP datapath
package ag_tcu_int_pkg;

    localparam logic [2:0] FMT_I8 = 3'd0;
    localparam logic [2:0] FMT_U8 = 3'd1;
    localparam logic [2:0] FMT_I4 = 3'd2;
    localparam logic [2:0] FMT_U4 = 3'd3;

    localparam logic FMT_D_WRAP = 1'b0;
    localparam logic FMT_D_SAT  = 1'b1;

    localparam int LANE_SUMW = 18;
    // uint8 lanes reach 4*255*255 = 260100, so the signed lane sum needs one bit above LANE_SUMW
    localparam int LANE_ACCW = LANE_SUMW + 1;

    localparam logic signed [63:0] I32_MAX = 64'sd2147483647;
    localparam logic signed [63:0] I32_MIN = -64'sd2147483648;

    function automatic logic fmt_valid(input logic [2:0] f);
        return (f <= FMT_U4);
    endfunction

    // Returns {ovf, clamped int32}; callers sign-extend their W-bit result to 64 bits.
    function automatic logic [32:0] sat32(input logic signed [63:0] x);
        logic [32:0] r;
        if (x > I32_MAX) begin
            r = {1'b1, 32'h7FFF_FFFF};
        end else if (x < I32_MIN) begin
            r = {1'b1, 32'h8000_0000};
        end else begin
            r = {1'b0, x[31:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/ag_tcu_int_lane_mul.sv
// rtl/ag_tcu_int_lane_mul.sv - one lane: sub-word unpack, multiply and sum
module ag_tcu_int_lane_mul
    import ag_tcu_int_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             a,
    input  logic [XLEN-1:0]             b,
    input  logic [2:0]                  fmt_s,
    output logic signed [LANE_ACCW-1:0] lane_sum
);

    logic               is_signed;
    logic signed [8:0]  ea;
    logic signed [8:0]  eb;
    logic signed [17:0] prod;

    // Every element is widened to 9 signed bits so one multiplier shape covers all four formats.
    always_comb begin
        lane_sum  = '0;
        ea        = '0;
        eb        = '0;
        prod      = '0;
        is_signed = (fmt_s == FMT_I8) || (fmt_s == FMT_I4);
        if ((fmt_s == FMT_I8) || (fmt_s == FMT_U8)) begin
            for (int j = 0; j < XLEN / 8; j++) begin
                ea       = {is_signed & a[8*j+7], a[8*j +: 8]};
                eb       = {is_signed & b[8*j+7], b[8*j +: 8]};
                prod     = ea * eb;
                lane_sum = lane_sum + LANE_ACCW'(prod);
            end
        end else if ((fmt_s == FMT_I4) || (fmt_s == FMT_U4)) begin
            for (int j = 0; j < XLEN / 4; j++) begin
                ea       = {{5{is_signed & a[4*j+3]}}, a[4*j +: 4]};
                eb       = {{5{is_signed & b[4*j+3]}}, b[4*j +: 4]};
                prod     = ea * eb;
                lane_sum = lane_sum + LANE_ACCW'(prod);
            end
        end
    end

endmodule

// File: rtl/ag_tcu_fedp_int.sv
// rtl/ag_tcu_fedp_int.sv - 3-stage integer fused dot-product unit for the TCU
module ag_tcu_fedp_int
    import ag_tcu_int_pkg::*;
#(
    parameter int N       = 4,
    parameter int XLEN    = 32,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              valid_in,
    input  logic [2:0]        fmt_s,
    input  logic              fmt_d,
    input  logic [N*XLEN-1:0] a_row,
    input  logic [N*XLEN-1:0] b_col,
    input  logic [XLEN-1:0]   c_val,
    input  logic              clr_ovf,
    output logic [XLEN-1:0]   d_val,
    output logic              valid_out,
    output logic              ovf,
    output logic              fmt_err,
    output logic              ovf_sticky
);

    localparam int SUMW = LANE_ACCW + $clog2(N);
    localparam int ACCW = ((SUMW > 32) ? SUMW : 32) + 1;

    if (LATENCY != 3) begin : g_latency_chk
        $error("ag_tcu_fedp_int: LATENCY must be 3");
    end
    if (XLEN != 32) begin : g_xlen_chk
        $error("ag_tcu_fedp_int: XLEN must be 32");
    end
    if (N < 1) begin : g_n_chk
        $error("ag_tcu_fedp_int: N must be at least 1");
    end

    logic signed [LANE_ACCW-1:0] lane_sum [N];
    logic signed [LANE_ACCW-1:0] lane_q   [N];

    for (genvar g = 0; g < N; g++) begin : g_lane
        ag_tcu_int_lane_mul #(.XLEN(XLEN)) u_lane (
            .a        (a_row[g*XLEN +: XLEN]),
            .b        (b_col[g*XLEN +: XLEN]),
            .fmt_s    (fmt_s),
            .lane_sum (lane_sum[g])
        );
    end

    // S1: lane products
    logic            v1;
    logic            err1;
    logic            fmt_d1;
    logic [XLEN-1:0] c1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1     <= 1'b0;
            err1   <= 1'b0;
            fmt_d1 <= 1'b0;
            c1     <= '0;
            for (int i = 0; i < N; i++) lane_q[i] <= '0;
        end else if (enable) begin
            v1     <= valid_in;
            err1   <= !fmt_valid(fmt_s);
            fmt_d1 <= fmt_d;
            c1     <= c_val;
            for (int i = 0; i < N; i++) lane_q[i] <= lane_sum[i];
        end
    end

    // S2: reduction over lanes
    logic signed [SUMW-1:0] tree_sum;

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < N; i++) tree_sum = tree_sum + SUMW'(lane_q[i]);
    end

    logic                   v2;
    logic                   err2;
    logic                   fmt_d2;
    logic [XLEN-1:0]        c2;
    logic signed [SUMW-1:0] sum2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2     <= 1'b0;
            err2   <= 1'b0;
            fmt_d2 <= 1'b0;
            c2     <= '0;
            sum2   <= '0;
        end else if (enable) begin
            v2     <= v1;
            err2   <= err1;
            fmt_d2 <= fmt_d1;
            c2     <= c1;
            sum2   <= tree_sum;
        end
    end

    // S3: accumulate in a width that cannot overflow, then wrap or clamp to int32
    logic signed [ACCW-1:0] acc;
    logic [32:0]            sat_r;
    logic                   ovf_n;
    logic [31:0]            d_n;

    always_comb begin
        acc   = ACCW'(sum2) + ACCW'($signed(c2));
        sat_r = sat32(64'(acc));
        ovf_n = sat_r[32];
        d_n   = (fmt_d2 == FMT_D_SAT) ? sat_r[31:0] : acc[31:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out <= 1'b0;
            d_val     <= '0;
            ovf       <= 1'b0;
            fmt_err   <= 1'b0;
        end else if (enable) begin
            valid_out <= v2;
            if (v2) begin
                d_val   <= err2 ? '0 : d_n;
                ovf     <= !err2 && ovf_n;
                fmt_err <= err2;
            end else begin
                ovf     <= 1'b0;
                fmt_err <= 1'b0;
            end
        end
    end

    // A clear wins over a coincident set; that overflow is intentionally dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky <= 1'b0;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end else if (enable && v2 && !err2 && ovf_n) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ag_tcu_fedp_int.sv
// tb/tb_ag_tcu_fedp_int.sv - scoreboard bench for ag_tcu_fedp_int
module tb_ag_tcu_fedp_int;

    localparam int N = 4;

    logic           clk;
    logic           reset_n;
    logic           enable;
    logic           valid_in;
    logic [2:0]     fmt_s;
    logic           fmt_d;
    logic [N*32-1:0] a_row;
    logic [N*32-1:0] b_col;
    logic [31:0]    c_val;
    logic           clr_ovf;
    logic [31:0]    d_val;
    logic           valid_out;
    logic           ovf;
    logic           fmt_err;
    logic           ovf_sticky;

    ag_tcu_fedp_int #(.N(N), .XLEN(32), .LATENCY(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .valid_in   (valid_in),
        .fmt_s      (fmt_s),
        .fmt_d      (fmt_d),
        .a_row      (a_row),
        .b_col      (b_col),
        .c_val      (c_val),
        .clr_ovf    (clr_ovf),
        .d_val      (d_val),
        .valid_out  (valid_out),
        .ovf        (ovf),
        .fmt_err    (fmt_err),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        ovf;
        logic        err;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    logic en_q   = 1'b0;
    logic clr_q  = 1'b0;
    logic exp_sticky = 1'b0;
    logic have_prev  = 1'b0;
    logic [31:0] last_d;
    logic last_v, last_ovf, last_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: element-wise arithmetic on the unpacked sub-words, in 64-bit integers.
    function automatic exp_t model(input logic [N*32-1:0] a, input logic [N*32-1:0] b,
                                   input logic [31:0] c, input logic [2:0] fs, input logic fd);
        exp_t   m;
        longint total, ea, eb;
        int     w, sh;
        bit     sgn;
        m.tag = 0;
        if (fs > 3) begin
            m.d = 32'd0; m.ovf = 1'b0; m.err = 1'b1;
            return m;
        end
        w     = (fs < 2) ? 8 : 4;
        sgn   = (fs == 0) || (fs == 2);
        total = longint'($signed(c));
        for (int ln = 0; ln < N; ln++) begin
            for (int k = 0; k < 32 / w; k++) begin
                sh = ln * 32 + k * w;
                ea = 0;
                eb = 0;
                for (int t = 0; t < w; t++) begin
                    ea += longint'(a[sh+t]) << t;
                    eb += longint'(b[sh+t]) << t;
                end
                if (sgn && ea >= (longint'(1) << (w - 1))) ea -= (longint'(1) << w);
                if (sgn && eb >= (longint'(1) << (w - 1))) eb -= (longint'(1) << w);
                total += ea * eb;
            end
        end
        m.err = 1'b0;
        m.ovf = (total > 64'sd2147483647) || (total < -64'sd2147483648);
        if (m.ovf && fd) m.d = (total > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else             m.d = total[31:0];
        return m;
    endfunction

    // Stimulus side of the scoreboard: every accepted operation pushes its expectation.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            en_cnt = 0;
            en_q   = 1'b0;
            clr_q  = 1'b0;
        end else begin
            exp_t e;
            en_q  = enable;
            clr_q = clr_ovf;
            if (enable) begin
                if (valid_in) begin
                    e     = model(a_row, b_col, c_val, fmt_s, fmt_d);
                    e.tag = en_cnt;
                    q.push_back(e);
                end
                en_cnt++;
            end
        end
    end

    // Monitor side
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_valid_out", valid_out, 0);
            chk("rst_d_val", d_val, 0);
            chk("rst_sticky", ovf_sticky, 0);
            chk("rst_ovf_err", {ovf, fmt_err}, 0);
            exp_sticky = 1'b0;
            have_prev  = 1'b0;
        end else begin
            logic set_s;
            exp_t e;
            set_s = 1'b0;
            if (en_q) begin
                if (valid_out) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid_out", valid_out, 0);
                    end else begin
                        e = q.pop_front();
                        chk("d_val", d_val, e.d);
                        chk("ovf", ovf, e.ovf);
                        chk("fmt_err", fmt_err, e.err);
                        chk("latency", en_cnt - e.tag, 3);
                        set_s = e.ovf;
                    end
                end else begin
                    chk("bubble_flags", {ovf, fmt_err}, 0);
                end
            end else if (have_prev) begin
                chk("stall_hold", {valid_out, d_val, ovf, fmt_err}, {last_v, last_d, last_ovf, last_err});
            end
            exp_sticky = clr_q ? 1'b0 : (exp_sticky | set_s);
            chk("ovf_sticky", ovf_sticky, exp_sticky);
            last_v    = valid_out;
            last_d    = d_val;
            last_ovf  = ovf;
            last_err  = fmt_err;
            have_prev = 1'b1;
        end
    end

    task automatic op(input logic [N*32-1:0] a, input logic [N*32-1:0] b,
                      input logic [31:0] c, input logic [2:0] fs, input logic fd);
        a_row = a; b_col = b; c_val = c; fmt_s = fs; fmt_d = fd; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        enable   = 1'b1;
        valid_in = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    logic [N*32-1:0] ff_all, two_all, n8_all, n1_all;

    initial begin
        ff_all  = {N*4{8'hFF}};
        two_all = {N*4{8'h02}};
        n8_all  = {N*8{4'h8}};
        n1_all  = {N*8{4'h1}};
        reset_n = 1'b0; enable = 1'b1; valid_in = 1'b0; clr_ovf = 1'b0;
        fmt_s = 3'd0; fmt_d = 1'b0; a_row = '0; b_col = '0; c_val = '0;
        for (int i = 0; i < 6; i++) begin
            valid_in = ~valid_in;
            a_row = {$urandom, $urandom, $urandom, $urandom};
            b_col = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        reset_n  = 1'b1;
        idle(1);

        op(two_all, two_all, 32'd10, 3'd0, 1'b0);
        op(ff_all, ff_all, 32'd0, 3'd0, 1'b0);
        op(ff_all, ff_all, 32'd0, 3'd1, 1'b0);
        op(n8_all, n8_all, -32'sd5, 3'd2, 1'b0);
        op(n8_all, n8_all, -32'sd5, 3'd3, 1'b0);
        op(n8_all, n1_all, 32'd0, 3'd2, 1'b0);
        op(n8_all, n1_all, 32'd0, 3'd3, 1'b0);
        drain();

        op(ff_all, ff_all, 32'h7FFF_FF00, 3'd1, 1'b1);
        op(ff_all, ff_all, 32'h7FFF_FF00, 3'd1, 1'b0);
        drain();
        chk("sticky_after_sat", ovf_sticky, 1);

        op(two_all, ff_all, 32'd7, 3'd5, 1'b0);
        drain();
        chk("sticky_after_fmt_err", ovf_sticky, 1);

        // clear coincides with the load of an overflowing result
        clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
        op(ff_all, ff_all, 32'h7FFF_FF00, 3'd1, 1'b1);
        idle(1);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("clr_load_ovf_seen", {valid_out, ovf}, 2'b11);
        chk("clr_priority", ovf_sticky, 0);
        drain();

        // stall mid-stream, then a bubble
        op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, $urandom, 3'd0, 1'b0);
        op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, $urandom, 3'd2, 1'b1);
        enable = 1'b0;
        valid_in = 1'b1;
        idle(5);
        valid_in = 1'b0;
        enable = 1'b1;
        idle(1);
        op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, $urandom, 3'd3, 1'b0);
        drain();

        for (int i = 0; i < 400; i++) begin
            int sel;
            enable   = ($urandom_range(99) < 85);
            valid_in = ($urandom_range(99) < 70);
            clr_ovf  = ($urandom_range(99) < 4);
            a_row    = {$urandom, $urandom, $urandom, $urandom};
            b_col    = {$urandom, $urandom, $urandom, $urandom};
            fmt_s    = ($urandom_range(9) < 8) ? 3'($urandom_range(3)) : 3'($urandom_range(7));
            fmt_d    = 1'($urandom_range(1));
            sel      = $urandom_range(2);
            if (sel == 0)      c_val = $urandom;
            else if (sel == 1) c_val = 32'h7FFF_0000 + 32'($urandom_range(65535));
            else               c_val = 32'h8000_0000 + 32'($urandom_range(65535));
            @(posedge clk); #1;
        end
        clr_ovf = 1'b0;
        drain();

        // reset with results in flight: none may emerge afterwards
        op(ff_all, two_all, 32'd1, 3'd0, 1'b0);
        op(ff_all, two_all, 32'd2, 3'd1, 1'b0);
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(6);
        chk("post_reset_quiet", valid_out, 0);
        chk("post_reset_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
